// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared types and constants for the pipeline hazard/stall sequencer:
//   - hazard_state_t : sequencer state (RUN, MEM_WAIT)
//   - RV32I major opcode constants used for source-register decoding
//   - uses_rs1 / uses_rs2 : which source fields an opcode actually reads
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // True when the opcode reads its rs1 field as a register operand.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE,
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: used = 1'b1;
            default:                                used = 1'b0;
        endcase
        return used;
    endfunction

    // True when the opcode reads its rs2 field as a register operand.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: used = 1'b1;
            default:                                used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous active-low reset and synchronous
// clear. Priority: reset, clear, increment. Holds at all-ones.
// Ports:
//   clk      : clock
//   reset    : synchronous active-low reset
//   clr_i    : synchronous clear to zero
//   inc_i    : increment by one (unless saturated)
//   count_o  : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-count selection: clear beats increment, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard and stall sequencer for the 5-stage pipeline. Handles the hazards
// forwarding cannot: load-use, taken-branch squash and data-memory wait.
// Control outputs are combinational (same-cycle) from state and inputs.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   id_instr_opcode_ip    : decode-stage opcode
//   id_rs1_ip, id_rs2_ip  : decode-stage source fields
//   ex_is_load_ip         : ID/EX instruction is a load
//   ex_dest_ip            : ID/EX destination register
//   ex_branch_taken_ip    : branch/jump resolved taken in EX
//   mem_req_ip            : EX/MEM instruction accesses data memory
//   mem_ready_ip          : data memory completes this cycle
//   cnt_clr_ip            : synchronous clear of both counters
//   pc_stall_op, if_id_stall_op, if_id_flush_op, id_ex_flush_op, freeze_op
//                         : pipeline control
//   stall_cycles_op       : saturating count of freeze / load-use stall cycles
//   flush_count_op        : saturating count of taken-branch flushes
//   state_op              : current hazard_state_t (debug)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       id_instr_opcode_ip,
    input  logic [4:0]       id_rs1_ip,
    input  logic [4:0]       id_rs2_ip,
    input  logic             ex_is_load_ip,
    input  logic [4:0]       ex_dest_ip,
    input  logic             ex_branch_taken_ip,
    input  logic             mem_req_ip,
    input  logic             mem_ready_ip,
    input  logic             cnt_clr_ip,
    output logic             pc_stall_op,
    output logic             if_id_stall_op,
    output logic             if_id_flush_op,
    output logic             id_ex_flush_op,
    output logic             freeze_op,
    output logic [CNT_W-1:0] stall_cycles_op,
    output logic [CNT_W-1:0] flush_count_op,
    output logic             state_op
);

    hazard_state_t state_q;
    hazard_state_t state_d;

    logic lu_s;
    logic freeze_s;
    logic eval_s;
    logic stall_inc_s;
    logic flush_inc_s;

    // Load-use detection; x0 destinations and unread source fields never match.
    always_comb begin
        lu_s = 1'b0;
        if (ex_is_load_ip && (ex_dest_ip != 5'd0)) begin
            lu_s = (uses_rs1(id_instr_opcode_ip) && (ex_dest_ip == id_rs1_ip)) ||
                   (uses_rs2(id_instr_opcode_ip) && (ex_dest_ip == id_rs2_ip));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Next-state logic; eval_s marks cycles where branch/load-use rules apply.
    always_comb begin
        state_d  = state_q;
        freeze_s = 1'b0;
        eval_s   = 1'b0;
        case (state_q)
            RUN: begin
                // A request that completes in the same cycle needs no freeze.
                if (mem_req_ip && !mem_ready_ip) begin
                    freeze_s = 1'b1;
                    state_d  = MEM_WAIT;
                end else begin
                    eval_s   = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The ready cycle is unfrozen and re-evaluates the held inputs.
                if (!mem_ready_ip) begin
                    freeze_s = 1'b1;
                end else begin
                    state_d  = RUN;
                    eval_s   = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        pc_stall_op    = 1'b0;
        if_id_stall_op = 1'b0;
        if_id_flush_op = 1'b0;
        id_ex_flush_op = 1'b0;
        freeze_op      = 1'b0;
        stall_inc_s    = 1'b0;
        flush_inc_s    = 1'b0;
        if (!reset) begin
            freeze_op = 1'b0;
        end else if (freeze_s) begin
            freeze_op   = 1'b1;
            stall_inc_s = 1'b1;
        end else if (eval_s && ex_branch_taken_ip) begin
            // A coincident load-use is moot: the dependent instruction is squashed.
            if_id_flush_op = 1'b1;
            id_ex_flush_op = 1'b1;
            flush_inc_s    = 1'b1;
        end else if (eval_s && lu_s) begin
            pc_stall_op    = 1'b1;
            if_id_stall_op = 1'b1;
            id_ex_flush_op = 1'b1;
            stall_inc_s    = 1'b1;
        end else begin
            freeze_op = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_op = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr_ip),
        .inc_i   (stall_inc_s),
        .count_o (stall_cycles_op)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr_ip),
        .inc_i   (flush_inc_s),
        .count_o (flush_count_op)
    );

endmodule
